// File: rtl/backchannel_ctrl.sv
// backchannel_ctrl: command sequencer for the backchannel UART.
// 0xAB streams the regfile (FILE_SIZE_BYTES bytes) and 0xAC streams the
// 7-byte thunderbolt time snapshot. Bytes go to uart_tx one at a time, and
// each byte waits for the done strobe from uart_tx before the next one starts.
module backchannel_ctrl #(
    parameter int FILE_SIZE_BYTES = 25
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_read,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_byte,
    input  logic       i_thunder_packet_dv,
    input  logic [7:0] i_thunder_year_h,
    input  logic [7:0] i_thunder_year_l,
    input  logic [7:0] i_thunder_month,
    input  logic [7:0] i_thunder_day,
    input  logic [7:0] i_thunder_hour,
    input  logic [7:0] i_thunder_minutes,
    input  logic [7:0] i_thunder_seconds,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    output logic       o_busy
);

    localparam logic [7:0] CMD_DUMP_REGS = 8'hAB;
    localparam logic [7:0] CMD_DUMP_TIME = 8'hAC;

    // Index of the final byte of each dump. The counter is 9 bits wide so a
    // 256-byte regfile reaches index 255 without wrapping.
    localparam logic [8:0] LAST_REG  = 9'(FILE_SIZE_BYTES - 1);
    localparam logic [8:0] LAST_TIME = 9'd6;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  count;
    logic        snap_mode;
    logic [7:0]  snap [7];

    logic        start_regs;
    logic        start_time;
    logic        advance;
    logic        last_byte;
    logic [2:0]  snap_idx;
    logic [7:0]  snap_pick;

    assign last_byte = (count == (snap_mode ? LAST_TIME : LAST_REG));
    assign o_rd_addr = count[7:0];
    assign o_busy    = (state != IDLE);

    // State register; reset aborts any dump in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the one-cycle read and transmit strobes.
    always_comb begin
        state_next = state;
        o_read     = 1'b0;
        o_tx_dv    = 1'b0;
        start_regs = 1'b0;
        start_time = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                // Commands are decoded only here; strobes in other states are dropped.
                if (i_rx_dv && (i_rx_byte == CMD_DUMP_REGS)) begin
                    start_regs = 1'b1;
                    state_next = RD_REQ;
                end else if (i_rx_dv && (i_rx_byte == CMD_DUMP_TIME)) begin
                    start_time = 1'b1;
                    state_next = TX_LOAD;
                end
            end
            RD_REQ: begin
                o_read     = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                state_next = TX_LOAD;
            end
            TX_LOAD: begin
                o_tx_dv    = 1'b1;
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (last_byte) begin
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = snap_mode ? TX_LOAD : RD_REQ;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pick the snapshot byte for the next TX_LOAD. At command accept a packet
    // arriving in the same cycle is forwarded directly so the fresh time is sent.
    always_comb begin
        snap_idx = start_time ? 3'd0 : (count[2:0] + 3'd1);
        case (snap_idx)
            3'd0:    snap_pick = snap[0];
            3'd1:    snap_pick = snap[1];
            3'd2:    snap_pick = snap[2];
            3'd3:    snap_pick = snap[3];
            3'd4:    snap_pick = snap[4];
            3'd5:    snap_pick = snap[5];
            default: snap_pick = snap[6];
        endcase
        if (start_time && i_thunder_packet_dv) begin
            snap_pick = i_thunder_year_h;
        end
    end

    // Time snapshot: follows every packet while idle, frozen during a dump.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 7; i++) begin
                snap[i] <= 8'h00;
            end
        end else if ((state == IDLE) && i_thunder_packet_dv) begin
            snap[0] <= i_thunder_year_h;
            snap[1] <= i_thunder_year_l;
            snap[2] <= i_thunder_month;
            snap[3] <= i_thunder_day;
            snap[4] <= i_thunder_hour;
            snap[5] <= i_thunder_minutes;
            snap[6] <= i_thunder_seconds;
        end
    end

    // Byte counter, dump mode and the held transmit byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count     <= 9'd0;
            snap_mode <= 1'b0;
            o_tx_byte <= 8'h00;
        end else begin
            if (start_regs) begin
                count     <= 9'd0;
                snap_mode <= 1'b0;
            end
            if (start_time) begin
                count     <= 9'd0;
                snap_mode <= 1'b1;
                o_tx_byte <= snap_pick;
            end
            if (advance) begin
                count <= count + 9'd1;
                if (snap_mode) begin
                    o_tx_byte <= snap_pick;
                end
            end
            // Regfile data is valid the cycle after the read strobe.
            if (state == RD_WAIT) begin
                o_tx_byte <= i_rd_byte;
            end
        end
    end

    // The handshake strobes are single-cycle by construction.
    a_tx_dv_single: assert property (@(posedge i_clk) disable iff (i_rst) o_tx_dv |=> !o_tx_dv);
    a_read_single:  assert property (@(posedge i_clk) disable iff (i_rst) o_read |=> !o_read);

endmodule

// File: tb/tb_backchannel_ctrl.sv
// tb_backchannel_ctrl: drives backchannel_ctrl with a modelled regfile and
// uart_tx, and compares every cycle against a timing/byte scoreboard.
module tb_backchannel_ctrl;

    localparam int FSZ = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx_dv, pkt, tx_done;
    logic [7:0] rx_byte, rd_byte;
    logic [7:0] f_yh, f_yl, f_mo, f_dy, f_hr, f_mi, f_se;
    logic       rd, tx_dv, busy;
    logic [7:0] rd_addr, tx_byte;

    logic       rx_dv2, pkt2, tx_done2;
    logic [7:0] rx_byte2, rd_byte2;
    logic       rd2, tx_dv2, busy2;
    logic [7:0] rd_addr2, tx_byte2;

    backchannel_ctrl #(.FILE_SIZE_BYTES(FSZ)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .o_read(rd), .o_rd_addr(rd_addr), .i_rd_byte(rd_byte),
        .i_thunder_packet_dv(pkt),
        .i_thunder_year_h(f_yh), .i_thunder_year_l(f_yl), .i_thunder_month(f_mo),
        .i_thunder_day(f_dy), .i_thunder_hour(f_hr), .i_thunder_minutes(f_mi),
        .i_thunder_seconds(f_se),
        .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_done(tx_done), .o_busy(busy)
    );

    backchannel_ctrl #(.FILE_SIZE_BYTES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv2), .i_rx_byte(rx_byte2),
        .o_read(rd2), .o_rd_addr(rd_addr2), .i_rd_byte(rd_byte2),
        .i_thunder_packet_dv(pkt2),
        .i_thunder_year_h(f_yh), .i_thunder_year_l(f_yl), .i_thunder_month(f_mo),
        .i_thunder_day(f_dy), .i_thunder_hour(f_hr), .i_thunder_minutes(f_mi),
        .i_thunder_seconds(f_se),
        .o_tx_dv(tx_dv2), .o_tx_byte(tx_byte2), .i_tx_done(tx_done2), .o_busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Environment content and scoreboard state.
    logic [7:0] mem [256];
    logic [7:0] snap [7];
    logic [7:0] exp_time [7] = '{8'h07, 8'hE8, 8'h03, 8'h0F, 8'h0C, 8'h22, 8'h38};
    logic [7:0] tx_log [$];
    int  cyc = 0, rd_at = -1, tx_at = -1, idx = 0, done_at = -1, fixed_dly = 20;
    int  tx_count = 0, rd_count = 0;
    bit  m_busy = 0, m_ab = 0, waiting = 0, after_rst = 1, chk_en = 0;
    bit  rd_pend = 0, stray_req = 0;
    logic [7:0] rd_pend_addr = 8'h00;
    logic [7:0] exp_b;

    // Per cycle: check outputs against expectations, play regfile and uart_tx,
    // then advance the reference by this cycle's inputs.
    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (chk_en) begin
            check_eq("o_read", rd, rd_at == cyc);
            if (rd_at == cyc) check_eq("o_rd_addr", rd_addr, idx);
            check_eq("o_tx_dv", tx_dv, tx_at == cyc);
            if (tx_at == cyc) begin
                if (m_ab) exp_b = mem[idx];
                else      exp_b = snap[idx];
                check_eq("o_tx_byte", tx_byte, exp_b);
            end
            check_eq("o_busy", busy, m_busy);
            if (after_rst) begin
                check_eq("rst_tx_byte", tx_byte, 0);
                check_eq("rst_rd_addr", rd_addr, 0);
            end
        end
        if (tx_dv) begin tx_count++; tx_log.push_back(tx_byte); end
        if (rd) rd_count++;

        rd_byte = rd_pend ? mem[rd_pend_addr] : 8'($urandom);
        rd_pend = rd;
        rd_pend_addr = rd_addr;

        tx_done = (done_at == cyc) || stray_req;
        stray_req = 0;
        if (tx_dv) done_at = cyc + ((fixed_dly > 0) ? fixed_dly : int'($urandom_range(25, 1)));
        if (rst) done_at = -1;

        if (rst) begin
            m_busy = 0; rd_at = -1; tx_at = -1; waiting = 0; after_rst = 1;
            for (int i = 0; i < 7; i++) snap[i] = 8'h00;
        end else if (!m_busy) begin
            if (pkt) begin
                snap[0] = f_yh; snap[1] = f_yl; snap[2] = f_mo; snap[3] = f_dy;
                snap[4] = f_hr; snap[5] = f_mi; snap[6] = f_se;
            end
            if (rx_dv && rx_byte == 8'hAB) begin
                m_busy = 1; m_ab = 1; idx = 0; rd_at = cyc + 1; tx_at = cyc + 3;
                waiting = 0; after_rst = 0;
            end else if (rx_dv && rx_byte == 8'hAC) begin
                m_busy = 1; m_ab = 0; idx = 0; rd_at = -1; tx_at = cyc + 1;
                waiting = 0; after_rst = 0;
            end
        end else begin
            if (waiting && tx_done) begin
                waiting = 0;
                if (idx == (m_ab ? FSZ - 1 : 6)) begin
                    m_busy = 0; rd_at = -1; tx_at = -1;
                end else begin
                    idx++;
                    if (m_ab) begin rd_at = cyc + 1; tx_at = cyc + 3; end
                    else tx_at = cyc + 1;
                end
            end
            if (cyc == tx_at) waiting = 1;
        end
    end

    task automatic send(input logic [7:0] b, input bit with_pkt);
        @(negedge clk); rx_dv = 1; rx_byte = b; pkt = with_pkt;
        @(negedge clk); rx_dv = 0; pkt = 0;
    endtask

    task automatic set_fields(input logic [7:0] a, b, c, d, e, f, g);
        f_yh = a; f_yl = b; f_mo = c; f_dy = d; f_hr = e; f_mi = f; f_se = g;
    endtask

    task automatic clear_logs();
        tx_count = 0; rd_count = 0; tx_log.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        do begin @(negedge clk); #2; n++; end while ((m_busy || busy) && n < max_cyc);
        check_eq("idle_timeout", {31'd0, m_busy || busy}, 0);
    endtask

    task automatic wait_tx(input int target, input int max_cyc);
        int n = 0;
        do begin @(negedge clk); #2; n++; end while (tx_count < target && n < max_cyc);
        check_eq("tx_timeout", tx_count >= target, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; rx_dv = 0; rx_byte = 0; pkt = 0; tx_done = 0; rd_byte = 0;
        rx_dv2 = 0; rx_byte2 = 0; rd_byte2 = 0; tx_done2 = 0; pkt2 = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) mem[k] = 8'(8'hA0 + k);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0; chk_en = 1;
        #2;
        check_eq("rst_o_read", rd, 0);
        check_eq("rst_o_tx_dv", tx_dv, 0);
        check_eq("rst_o_busy", busy, 0);
        check_eq("rst_o_tx_byte", tx_byte, 0);
        check_eq("rst_o_rd_addr", rd_addr, 0);
        check_eq("rst1_o_busy", busy2, 0);
        clear_logs();
        repeat (1000) @(negedge clk);
        #2;
        check_eq("idle_tx_count", tx_count, 0);
        check_eq("idle_rd_count", rd_count, 0);

        // Regfile dump, done 20 cycles after each start.
        clear_logs();
        send(8'hAB, 0);
        wait_idle(2000);
        check_eq("rf_tx_count", tx_count, FSZ);
        check_eq("rf_rd_count", rd_count, FSZ);
        for (int i = 0; i < tx_log.size(); i++) check_eq("rf_byte", tx_log[i], 8'(8'hA0 + i));

        // Time dump with a second packet arriving mid-dump.
        @(negedge clk); set_fields(8'h07, 8'hE8, 8'h03, 8'h0F, 8'h0C, 8'h22, 8'h38); pkt = 1;
        @(negedge clk); pkt = 0;
        #2; clear_logs();
        send(8'hAC, 0);
        wait_tx(3, 500);
        @(negedge clk); set_fields(8'h08, 8'h01, 8'h0B, 8'h1C, 8'h17, 8'h3B, 8'h3A); pkt = 1;
        @(negedge clk); pkt = 0;
        wait_idle(1000);
        check_eq("time_tx_count", tx_count, 7);
        for (int i = 0; i < tx_log.size() && i < 7; i++) check_eq("time_byte", tx_log[i], exp_time[i]);

        // Invalid command, then a command overlapping a dump.
        clear_logs();
        send(8'h55, 0);
        repeat (50) @(negedge clk);
        #2;
        check_eq("inv_tx_count", tx_count, 0);
        check_eq("inv_rd_count", rd_count, 0);
        check_eq("inv_busy", busy, 0);
        clear_logs();
        send(8'hAB, 0);
        repeat (10) @(negedge clk);
        send(8'hAC, 0);
        wait_idle(2000);
        check_eq("ovl_tx_count", tx_count, FSZ);
        for (int i = 0; i < tx_log.size(); i++) check_eq("ovl_byte", tx_log[i], 8'(8'hA0 + i));

        // Reset after the fifth byte, then restart.
        clear_logs();
        send(8'hAB, 0);
        wait_tx(5, 1000);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        #2;
        check_eq("mrst_o_busy", busy, 0);
        check_eq("mrst_o_read", rd, 0);
        check_eq("mrst_o_tx_dv", tx_dv, 0);
        check_eq("mrst_o_tx_byte", tx_byte, 0);
        check_eq("mrst_o_rd_addr", rd_addr, 0);
        repeat (30) @(negedge clk);
        #2;
        check_eq("mrst_tx_count", tx_count, 5);
        clear_logs();
        send(8'hAB, 0);
        wait_idle(2000);
        check_eq("mrst_restart_count", tx_count, FSZ);
        if (tx_log.size() > 0) check_eq("mrst_restart_first", tx_log[0], 8'hA0);

        // Packet in the same cycle as the 0xAC accept is the one sent.
        @(negedge clk); set_fields(8'h07, 8'hE9, 8'h0C, 8'h1F, 8'h17, 8'h3B, 8'h3B);
        #2; clear_logs();
        send(8'hAC, 1);
        wait_idle(1000);
        check_eq("same_tx_count", tx_count, 7);
        if (tx_log.size() == 7) begin
            check_eq("same_b0", tx_log[0], 8'h07);
            check_eq("same_b1", tx_log[1], 8'hE9);
            check_eq("same_b6", tx_log[6], 8'h3B);
        end

        // Randomized traffic: random contents, delays, commands and strays.
        fixed_dly = 0;
        for (int it = 0; it < 10; it++) begin
            logic [7:0] cmd;
            for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
            @(negedge clk);
            set_fields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom));
            pkt = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) begin
                @(negedge clk); pkt = 0; stray_req = ($urandom_range(0, 3) == 0);
            end
            case ($urandom_range(0, 3))
                0, 1:    cmd = 8'hAB;
                2:       cmd = 8'hAC;
                default: cmd = 8'($urandom);
            endcase
            send(cmd, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 40)) @(negedge clk);
            @(negedge clk);
            rx_dv = 1; rx_byte = ($urandom_range(0, 1) == 1) ? 8'hAC : 8'hAB;
            set_fields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom));
            pkt = 1;
            @(negedge clk); rx_dv = 0; pkt = 0;
            wait_idle(3000);
        end

        // Single-byte regfile instance.
        @(negedge clk); rx_dv2 = 1; rx_byte2 = 8'hAB; #2;
        check_eq("p1_busy_accept", busy2, 0);
        @(negedge clk); rx_dv2 = 0; #2;
        check_eq("p1_read", rd2, 1);
        check_eq("p1_addr", rd_addr2, 0);
        check_eq("p1_busy", busy2, 1);
        @(negedge clk); rd_byte2 = 8'h5A; #2;
        check_eq("p1_read_wait", rd2, 0);
        check_eq("p1_tx_wait", tx_dv2, 0);
        @(negedge clk); rd_byte2 = 8'hFF; #2;
        check_eq("p1_tx_dv", tx_dv2, 1);
        check_eq("p1_tx_byte", tx_byte2, 8'h5A);
        n = 0;
        repeat (5) begin @(negedge clk); #2; if (rd2 || tx_dv2) n++; end
        check_eq("p1_no_extra", n, 0);
        @(negedge clk); tx_done2 = 1; #2;
        check_eq("p1_busy_done", busy2, 1);
        @(negedge clk); tx_done2 = 0; #2;
        check_eq("p1_idle", busy2, 0);
        n = 0;
        repeat (20) begin @(negedge clk); #2; if (rd2 || tx_dv2 || busy2) n++; end
        check_eq("p1_quiet", n, 0);
        @(negedge clk); tx_done2 = 1;
        @(negedge clk); tx_done2 = 0;
        n = 0;
        repeat (10) begin @(negedge clk); #2; if (rd2 || tx_dv2 || busy2) n++; end
        check_eq("p1_stray_done", n, 0);
        check_eq("p1_byte_held", tx_byte2, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/backchannel_ctrl.md
# backchannel_ctrl

Sequencer for the backchannel UART. It decodes command bytes from `uart_rx`, drives the regfile read port, and streams bytes to `uart_tx` one at a time over a done-handshake. It sits between `uart_rx`/`uart_tx`, the regfile read port and the thunderbolt time outputs. It serves two commands: 0xAB dumps the whole regfile, and 0xAC dumps the latest thunderbolt time packet.

## Interface
- `FILE_SIZE_BYTES`, 25, number of regfile bytes sent by 0xAB; legal range 1-256.
- `i_clk` input 1: system clock (10 MHz).
- `i_rst` input 1: synchronous, active-high reset.
- `i_rx_dv` input 1: one-cycle strobe from `uart_rx`; `i_rx_byte` is valid in that cycle.
- `i_rx_byte` input 8: received command byte.
- `o_read` output 1: regfile read strobe.
- `o_rd_addr` output 8: regfile read address.
- `i_rd_byte` input 8: regfile read data, valid exactly one cycle after `o_read`.
- `i_thunder_packet_dv` input 1: one-cycle strobe; the thunderbolt fields are valid in that cycle.
- `i_thunder_year_h`, `i_thunder_year_l`, `i_thunder_month`, `i_thunder_day`, `i_thunder_hour`, `i_thunder_minutes`, `i_thunder_seconds`, each input 8: thunderbolt time fields.
- `o_tx_dv` output 1: one-cycle strobe to `uart_tx` to start sending `o_tx_byte`.
- `o_tx_byte` output 8: byte to transmit; held until the next `o_tx_dv`.
- `i_tx_done` input 1: one-cycle strobe from `uart_tx` when the stop bit completes.
- `o_busy` output 1: high while a dump is in progress.

## Operation
- **Reset.** All outputs are 0. State is IDLE. The byte counter is 0. The snapshot registers are all 0.
- **Snapshot.** A 7-byte snapshot is loaded from the thunderbolt fields on every `i_thunder_packet_dv`, but only while in IDLE. It is frozen while `o_busy` is high. If `i_thunder_packet_dv` arrives in the same cycle that 0xAC is accepted, the new packet is loaded and sent.
- **Command decode.** Decoding happens only in IDLE. 0xAB goes to RD_REQ with counter = 0. 0xAC goes to TX_LOAD in snap mode with counter = 0. Any other byte is ignored. Any `i_rx_dv` while not in IDLE is dropped entirely; it is not queued.
- **State machine:**
  - RD_REQ: `o_read` = 1 and `o_rd_addr` = counter for one cycle, then go to RD_WAIT.
  - RD_WAIT: capture `i_rd_byte` into `o_tx_byte`, then go to TX_LOAD.
  - TX_LOAD: `o_tx_dv` = 1 for one cycle. In snap mode, `o_tx_byte` is taken from the snapshot at index counter, in order year_h, year_l, month, day, hour, minutes, seconds. Then go to TX_WAIT.
  - TX_WAIT: wait for `i_tx_done`. When it arrives:
    - If counter equals last (FILE_SIZE_BYTES-1 for 0xAB, 6 for 0xAC), go to IDLE.
    - Otherwise increment the counter and go to RD_REQ (0xAB) or TX_LOAD (0xAC).
- **Ignored strobes.** `i_tx_done` outside TX_WAIT is ignored.
- **Counter width.** The counter is 9 bits, so FILE_SIZE_BYTES = 256 does not wrap before completion. `o_rd_addr` = counter[7:0].
- **Reset mid-operation.** Abort immediately and apply the reset values. No partial byte is re-sent after reset.

## Timing
- **0xAB, first byte.** The command is accepted at cycle N (`i_rx_dv` high). Then:
  - N+1: `o_read` with address 0.
  - N+2: `i_rd_byte` is captured.
  - N+3: `o_tx_dv` is asserted.
- **0xAB, following bytes.** If `i_tx_done` arrives at cycle M, the next `o_read` is at M+1 and the next `o_tx_dv` is at M+3.
- **0xAC.** The command is accepted at N; `o_tx_dv` is asserted at N+1. If `i_tx_done` arrives at M, the next `o_tx_dv` is at M+1.
- **`o_busy`.** High from N+1 through the cycle of the final `i_tx_done`. Low from the next cycle. A new command is accepted from that cycle onward.
- **Strobe widths.** `o_read` and `o_tx_dv` are never high for more than one consecutive cycle.

## Test plan
- **Reset values.** Assert `i_rst` for 2 cycles, then release. Required: all outputs are 0 and `o_busy` = 0. With no command, `o_read` and `o_tx_dv` stay 0 for 1000 cycles.
- **Regfile dump.** Model the regfile with addr k holding 8'hA0+k and model `uart_tx` done 20 cycles after `o_tx_dv`, then send 0xAB. Required: exactly 25 `o_tx_dv` pulses with bytes A0..B8 in order, `o_rd_addr` sequence 0..24, and `o_busy` falls the cycle after the 25th done.
- **Time dump with mid-dump packet.** Pulse `i_thunder_packet_dv` with time 2024-03-15 12:34:56, send 0xAC, then pulse `i_thunder_packet_dv` again during byte 3 with different data. Required: bytes 07,E8,03,0F,0C,22,38 are sent, unaffected by the second packet.
- **Invalid and overlapping commands.** Send 0x55. Required: no activity. Then send 0xAB, and send 0xAC while `o_busy` is high. Required: only the 25-byte regfile dump occurs, with no time bytes appended.
- **Reset mid-dump.** Assert `i_rst` after the 5th `o_tx_dv` of a 0xAB dump. Required: next cycle all outputs are 0 and state is IDLE. A subsequent 0xAB restarts at address 0.
- **Parameter edge.** With FILE_SIZE_BYTES = 1, send 0xAB. Required: a single `o_read` with address 0, one `o_tx_dv`, then IDLE. A stray `i_tx_done` in IDLE causes no change.
